// File: rtl/pwm_driver.sv
// Double-buffered motor PWM generator with direction-change dead-time.
// Optional PWM_SOFTSTART_EN: ramp duty increases by RAMP_STEP per period.
module pwm_driver #(
  parameter int unsigned PRESCALE         = 4,
  parameter int unsigned DEADTIME_PERIODS = 2,
  parameter int unsigned RAMP_STEP        = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] active_ratio,
  output logic [1:0] debug_state
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = $clog2(DEADTIME_PERIODS + 1);
  localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DtInit   = DW'(DEADTIME_PERIODS);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRun      = 2'b01,
    StDeadtime = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    shadow_ratio_q, shadow_ratio_d;
  logic          shadow_dir_q, shadow_dir_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] dt_q, dt_d;
  logic [7:0]    active_q, active_d;
  logic          dir_q, dir_d;
  logic          out_q, out_d;
  logic          done_q, done_d;

  logic       tick;
  logic       boundary;
  logic       applied;
  logic [7:0] target_run;
  logic [7:0] target_zero;

`ifdef PWM_SOFTSTART_EN
  // Step toward the request by at most RAMP_STEP; decreases land immediately.
  function automatic logic [7:0] ramp_to(input logic [7:0] base, input logic [7:0] goal);
    logic [8:0] stepped;
    stepped = {1'b0, base} + 9'(RAMP_STEP);
    if ((goal > base) && (stepped < {1'b0, goal})) begin
      return stepped[7:0];
    end
    return goal;
  endfunction

  assign target_run  = ramp_to(active_q, shadow_ratio_q);
  assign target_zero = ramp_to(8'd0, shadow_ratio_q);
`else
  assign target_run  = shadow_ratio_q;
  assign target_zero = shadow_ratio_q;
`endif

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    cnt_d          = cnt_q;
    shadow_ratio_d = shadow_ratio_q;
    shadow_dir_d   = shadow_dir_q;
    pending_d      = pending_q;
    dt_d           = dt_q;
    active_d       = active_q;
    dir_d          = dir_q;
    out_d          = 1'b0;
    done_d         = 1'b0;
    applied        = 1'b0;

    tick     = (presc_q == PresLast);
    boundary = tick && (cnt_q == 8'd254);

    if (!pwm_enable) begin
      state_d   = StIdle;
      presc_d   = '0;
      cnt_d     = '0;
      active_d  = '0;
      pending_d = 1'b0;
      dt_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StRun;
          presc_d  = '0;
          cnt_d    = '0;
          active_d = '0;
        end
        StRun, StDeadtime: begin
          if (tick) begin
            presc_d = '0;
            cnt_d   = (cnt_q == 8'd254) ? 8'd0 : cnt_q + 8'd1;
          end else begin
            presc_d = presc_q + 1'b1;
          end

          if (boundary && (state_q == StRun) && pending_q) begin
            if (shadow_dir_q == dir_q) begin
              active_d = target_run;
              applied  = (target_run == shadow_ratio_q);
            end else begin
              state_d  = StDeadtime;
              active_d = '0;
              dt_d     = DtInit;
            end
          end else if (boundary && (state_q == StDeadtime)) begin
            if (dt_q == DW'(1)) begin
              dt_d     = '0;
              state_d  = StRun;
              dir_d    = shadow_dir_q;
              active_d = target_zero;
              applied  = (target_zero == shadow_ratio_q);
            end else begin
              dt_d = dt_q - 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (applied) begin
        pending_d = 1'b0;
        done_d    = 1'b1;
      end
      // A capture in the applying cycle itself re-arms pending for the next boundary.
      if (pwm_update) begin
        shadow_ratio_d = pwm_ratio;
        shadow_dir_d   = pwm_direction;
        pending_d      = 1'b1;
      end

      out_d = (state_d == StRun) && (cnt_d < active_d);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      cnt_q          <= '0;
      shadow_ratio_q <= '0;
      shadow_dir_q   <= 1'b0;
      pending_q      <= 1'b0;
      dt_q           <= '0;
      active_q       <= '0;
      dir_q          <= 1'b0;
      out_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      shadow_ratio_q <= shadow_ratio_d;
      shadow_dir_q   <= shadow_dir_d;
      pending_q      <= pending_d;
      dt_q           <= dt_d;
      active_q       <= active_d;
      dir_q          <= dir_d;
      out_q          <= out_d;
      done_q         <= done_d;
    end
  end

  assign pwm_done     = done_q;
  assign pwm_out      = out_q;
  assign dir_out      = dir_q;
  assign active_ratio = active_q;
  assign debug_state  = state_q;

endmodule

// File: doc/pwm_driver.md
Name: pwm_driver

Overview:
Motor PWM generator; consumes the PID controller's pwm_update/pwm_ratio/pwm_direction request interface and returns pwm_done.
- Double-buffers the requested duty and direction; applies them only at PWM period boundaries.
- On direction reversal, inserts a dead-time of forced-low periods before the new direction takes effect.
- Drives the H-bridge pwm_out and dir_out pins for one wheel's rotation motor.

Parameters:
PRESCALE, 4, clock cycles per PWM count step (>=1)
DEADTIME_PERIODS, 2, full PWM periods of forced-low output on a direction change (>=1)
RAMP_STEP, 16, max duty increase per period when PWM_SOFTSTART_EN is defined (1..255)

Ports:
clock  input  1  main clock
reset_n  input  1  synchronous active-low reset (sampled on posedge clock)
pwm_enable  input  1  run enable; low forces output off
pwm_update  input  1  request strobe/level; ratio and direction sampled every cycle it is high
pwm_ratio  input  8  requested high-time out of 255
pwm_direction  input  1  requested motor direction
pwm_done  output  1  one-cycle pulse: the requested ratio is now in effect
pwm_out  output  1  PWM drive to H-bridge
dir_out  output  1  direction drive to H-bridge
active_ratio  output  8  duty currently being generated
debug_state  output  2  current FSM state

Behaviour:
- Reset (reset_n low at posedge): pwm_done=0, pwm_out=0, dir_out=0, active_ratio=0, state=IDLE. Internal state also clears: prescaler=0, cnt=0, shadow ratio=0, shadow direction=0, pending=0, deadtime count=0.
- Prescaler counts 0..PRESCALE-1; tick asserts when prescaler==PRESCALE-1.
- cnt advances 0..254 on tick, then wraps to 0, so one period = 255*PRESCALE cycles.
- Boundary = tick while cnt==254.
- Shadow capture: any cycle with pwm_update=1 loads the shadow ratio and shadow direction from the inputs and sets pending.
  - The last sample before a boundary wins.
  - A capture in the boundary cycle itself is not applied at that boundary; it stays pending for the next one.
- pwm_out is registered and equals (next cnt < next active_ratio) in RUN; otherwise 0.
  - Ratio 0 gives a constant low output.
  - Ratio 255 gives a constant high output (cnt never reaches 255).
- FSM states: IDLE=00, RUN=01, DEADTIME=10.
  - IDLE: outputs low, prescaler/cnt held at 0. When pwm_enable=1, go to RUN next cycle with cnt=0, active_ratio=0, dir_out unchanged.
  - RUN, at a boundary with pending=1 and shadow direction == dir_out: active_ratio <= shadow ratio, pending cleared, pwm_done=1 in the following cycle (the first cycle of the new period).
  - RUN, at a boundary with pending=1 and shadow direction != dir_out: go to DEADTIME, active_ratio <= 0, deadtime count <= DEADTIME_PERIODS. pending stays set.
  - DEADTIME: pwm_out=0, cnt keeps running, deadtime count decrements at each boundary.
  - DEADTIME exit: at the boundary where the count reaches 0, dir_out <= shadow direction, active_ratio <= shadow ratio, pending cleared, pwm_done pulses next cycle, state goes to RUN.
  - If the shadow direction is updated back to dir_out during DEADTIME, dead-time still completes; then the ratio is applied with the unchanged direction.
- pwm_enable=0 in any state: go to IDLE next cycle.
  - pwm_out, active_ratio, cnt, prescaler, pending, pwm_done all forced to 0.
  - dir_out holds its value.
  - Enable takes priority over a simultaneous boundary or update.
- Reset asserted mid-period or mid-dead-time: all registers return to reset values at that clock edge.
- pwm_done never pulses without a pending request, and never pulses in two consecutive cycles.

Optional Feature:
PWM_SOFTSTART_EN
- Defined: at each applying boundary, if shadow > active_ratio, then active_ratio <= min(shadow, active_ratio+RAMP_STEP).
  - pending stays set, and pwm_done is withheld, until active_ratio == shadow.
  - Decreases apply in one step.
  - After DEADTIME, the ramp restarts from 0.
- Undefined: the full ratio is applied at the first applying boundary, as described above.

Test Plan:
1. PRESCALE=1, enable, then pwm_update=1 for one cycle with ratio=128, dir=0 -> at the first boundary active_ratio=128 and pwm_done pulses once; thereafter pwm_out is high exactly 128 of every 255 cycles.
2. Ratios 0 and 255 -> pwm_out constant 0 and constant 1 respectively across 3 periods; pwm_done pulses once per change.
3. Running at ratio 100 dir=0, request ratio 100 dir=1 -> pwm_out low for exactly 2*255 cycles, then dir_out=1, active_ratio=100, one pwm_done pulse.
4. pwm_update asserted in the boundary cycle with ratio 50 -> not applied at that boundary; applied at the next (+255 cycles).
5. Drop pwm_enable mid-period and mid-DEADTIME -> next cycle state=IDLE, pwm_out=0, active_ratio=0, dir_out unchanged; re-enable restarts at cnt=0.
6. PWM_SOFTSTART_EN, RAMP_STEP=16, request 40 from 0 -> active_ratio 16, 32, 40 on successive boundaries; pwm_done only after 40. Then request 10 -> applied in one boundary.
